// File: rtl/sequence_checker_pkg.sv
// rtl/sequence_checker_pkg.sv - shared types, key map and FSM encoding for sequence_checker
package sequence_checker_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 32;
  localparam int unsigned TILE_W_DEFAULT = 2;
  localparam int unsigned PTR_W          = 6;
  localparam int unsigned NUM_KEYS       = 4;

  typedef logic [TILE_W_DEFAULT-1:0] tile_t;

  localparam tile_t KEY0_TILE = 2'd0;
  localparam tile_t KEY1_TILE = 2'd1;
  localparam tile_t KEY2_TILE = 2'd2;
  localparam tile_t KEY3_TILE = 2'd3;

  localparam logic [NUM_KEYS-1:0] KEYS_RELEASED = 4'b1111;

  typedef enum logic [1:0] {
    ST_WAIT_RELEASE = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PENDING      = 2'd2
  } chk_state_e;

  // Keys are active-low; exactly one low key selects a tile
  function automatic logic is_single_press(input logic [NUM_KEYS-1:0] keys_n);
    return (keys_n == 4'b1110) || (keys_n == 4'b1101) ||
           (keys_n == 4'b1011) || (keys_n == 4'b0111);
  endfunction

  function automatic tile_t key_to_tile(input logic [NUM_KEYS-1:0] keys_n);
    tile_t t;
    case (keys_n)
      4'b1101: t = KEY1_TILE;
      4'b1011: t = KEY2_TILE;
      4'b0111: t = KEY3_TILE;
      default: t = KEY0_TILE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// rtl/key_sync_edge.sv - key synchronizer, optional debounce (KEY_DEBOUNCE_EN), single-press edge detect
module key_sync_edge
  import sequence_checker_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                press,
  output tile_t               press_tile,
  output logic                all_released
);

`ifdef KEY_DEBOUNCE_EN
  localparam bit USE_FILTER = 1'b1;
`else
  localparam bit USE_FILTER = 1'b0;
`endif

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [NUM_KEYS-1:0] filt;

  // Two-flop synchronizer feeding the filter, plus the previous filtered vector for edge detection
  always_comb begin
    sync1_d = keys;
    sync2_d = sync1_q;
    prev_d  = filt;
  end

  // Reset to "all pressed" so keys held through reset are never mistaken for a release
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  if (USE_FILTER && (DEBOUNCE_CYCLES > 1)) begin : g_debounce
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_KEYS-1:0] cand_q, cand_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Any change restarts the count; the vector is passed on once it has held long enough
    always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        stable_d = cand_q;
      end
    end

    // Debounce state registers
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        cand_q   <= '0;
        stable_q <= '0;
        cnt_q    <= '0;
      end else begin
        cand_q   <= cand_d;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign filt = stable_q;
  end else begin : g_direct
    assign filt = sync2_q;
  end

  assign all_released = (filt == KEYS_RELEASED);
  assign press        = is_single_press(filt) && (prev_q == KEYS_RELEASED);
  assign press_tile   = key_to_tile(filt);

endmodule

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - player-side sequence store and press checker (optional KEY_DEBOUNCE_EN)
module sequence_checker
  import sequence_checker_pkg::*;
#(
  parameter int unsigned DEPTH           = DEPTH_DEFAULT,
  parameter int unsigned TILE_W          = TILE_W_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              seq_clear,
  input  logic              seq_wr,
  input  logic [TILE_W-1:0] seq_tile,
  input  logic [4:0]        difficulty,
  input  logic              playerEN,
  input  logic              checkEN,
  input  logic [3:0]        keys,
  output logic              player_input,
  output logic              check,
  output logic [TILE_W-1:0] guess_tile,
  output logic [5:0]        guess_index,
  output logic              round_done,
  output logic              mismatch,
  output logic              overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   NEXT_ONE = (PTR_W + 1)'(1);

  logic [TILE_W-1:0] mem_q [DEPTH];

  chk_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [TILE_W-1:0] guess_tile_q, guess_tile_d;
  logic              player_input_q, player_input_d;
  logic              round_done_q, round_done_d;
  logic              mismatch_q, mismatch_d;
  logic              overflow_q, overflow_d;

  logic              press;
  logic              all_released;
  tile_t             press_tile;
  logic              wr_accept;
  logic              match;
  logic [TILE_W-1:0] expected_tile;
  logic [PTR_W:0]    rd_next;
  logic [PTR_W:0]    diff_ext;

  key_sync_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_sync_edge (
    .clock       (clock),
    .resetn      (resetn),
    .keys        (keys),
    .press       (press),
    .press_tile  (press_tile),
    .all_released(all_released)
  );

  // Pointers never exceed DEPTH, so the low bits are a safe index whenever rd_ptr < wr_ptr
  assign expected_tile = mem_q[rd_ptr_q[AW-1:0]];
  assign match         = player_input_q && (guess_tile_q == expected_tile) && (rd_ptr_q < wr_ptr_q);
  assign wr_accept     = seq_wr && !seq_clear && (wr_ptr_q < FULL_PTR);
  assign rd_next       = {1'b0, rd_ptr_q} + NEXT_ONE;
  assign diff_ext      = (PTR_W + 1)'(difficulty);

  // Next-state: seq_clear beats writes and checks; writes are independent of the press FSM
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    guess_tile_d = guess_tile_q;
    round_done_d = 1'b0;
    mismatch_d   = mismatch_q;
    overflow_d   = overflow_q;

    if (seq_clear) begin
      state_d    = ST_WAIT_RELEASE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mismatch_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (seq_wr) begin
        if (wr_ptr_q < FULL_PTR) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end

      case (state_q)
        ST_WAIT_RELEASE: begin
          if (all_released) begin
            state_d = ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (press) begin
            if (playerEN) begin
              state_d      = ST_PENDING;
              guess_tile_d = TILE_W'(press_tile);
            end else begin
              state_d = ST_WAIT_RELEASE;
            end
          end
        end
        ST_PENDING: begin
          if (checkEN) begin
            state_d = ST_WAIT_RELEASE;
            if (match) begin
              if (rd_next >= diff_ext) begin
                round_done_d = 1'b1;
                rd_ptr_d     = '0;
              end else begin
                rd_ptr_d = rd_next[PTR_W-1:0];
              end
            end else begin
              mismatch_d = 1'b1;
              rd_ptr_d   = '0;
            end
          end
        end
        default: state_d = ST_WAIT_RELEASE;
      endcase
    end

    player_input_d = (state_d == ST_PENDING);
  end

  // Checker FSM state, pointers and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_WAIT_RELEASE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      guess_tile_q   <= '0;
      player_input_q <= 1'b0;
      round_done_q   <= 1'b0;
      mismatch_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      guess_tile_q   <= guess_tile_d;
      player_input_q <= player_input_d;
      round_done_q   <= round_done_d;
      mismatch_q     <= mismatch_d;
      overflow_q     <= overflow_d;
    end
  end

  // Sequence storage; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= seq_tile;
    end
  end

  assign player_input = player_input_q;
  assign check        = match;
  assign guess_tile   = guess_tile_q;
  assign guess_index  = rd_ptr_q;
  assign round_done   = round_done_q;
  assign mismatch     = mismatch_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - self-checking bench for sequence_checker (KEY_DEBOUNCE_EN selects glitch test)
module tb_sequence_checker;

  localparam int DEPTH = 32;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       seq_clear = 1'b0;
  logic       seq_wr = 1'b0;
  logic [1:0] seq_tile = 2'd0;
  logic [4:0] difficulty = 5'd0;
  logic       playerEN = 1'b0;
  logic       checkEN = 1'b0;
  logic [3:0] keys = 4'hF;

  logic       player_input;
  logic       check;
  logic [1:0] guess_tile;
  logic [5:0] guess_index;
  logic       round_done;
  logic       mismatch;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int pi_rises = 0;
  bit pi_last = 1'b0;
  bit model_on = 1'b0;

  always #5 clock = ~clock;

  sequence_checker #(
    .DEPTH(DEPTH),
    .TILE_W(2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .seq_clear   (seq_clear),
    .seq_wr      (seq_wr),
    .seq_tile    (seq_tile),
    .difficulty  (difficulty),
    .playerEN    (playerEN),
    .checkEN     (checkEN),
    .keys        (keys),
    .player_input(player_input),
    .check       (check),
    .guess_tile  (guess_tile),
    .guess_index (guess_index),
    .round_done  (round_done),
    .mismatch    (mismatch),
    .overflow    (overflow)
  );

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the stored sequence is a queue, the player's progress an index into it
  int unsigned m_seq[$];
  logic [3:0]  m_keys[$];
  int          m_rd;
  int          m_guess;
  bit          m_pending, m_ready, m_rdone, m_mis, m_ovf;

  function automatic int low_key(input logic [3:0] k);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < 4; i++) begin
      if (!k[i]) begin
        n++;
        idx = i;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic bit m_check();
    if (!m_pending || m_rd >= int'(m_seq.size())) return 1'b0;
    return m_seq[m_rd] == m_guess;
  endfunction

  function automatic void model_reset();
    m_seq.delete();
    m_keys.delete();
    for (int i = 0; i < 3; i++) m_keys.push_back(4'h0);
    m_rd = 0; m_guess = 0;
    m_pending = 0; m_ready = 0; m_rdone = 0; m_mis = 0; m_ovf = 0;
  endfunction

  function automatic void model_step();
    logic [3:0] synced;
    logic [3:0] prev;
    int k;
    bit ok;
    bit was_pending;
    synced = m_keys[1];
    prev = m_keys[0];
    ok = m_check();
    was_pending = m_pending;
    m_rdone = 0;
    if (seq_clear) begin
      m_seq.delete();
      m_rd = 0; m_mis = 0; m_ovf = 0; m_pending = 0; m_ready = 0;
    end else begin
      if (seq_wr) begin
        if (m_seq.size() < DEPTH) m_seq.push_back(seq_tile);
        else m_ovf = 1;
      end
      if (was_pending) begin
        if (checkEN) begin
          m_pending = 0;
          m_ready = 0;
          if (ok) begin
            m_rd++;
            if (m_rd >= int'(difficulty)) begin
              m_rdone = 1;
              m_rd = 0;
            end
          end else begin
            m_mis = 1;
            m_rd = 0;
          end
        end
      end else if (m_ready) begin
        k = low_key(synced);
        if (k >= 0 && prev == 4'hF) begin
          if (playerEN) begin
            m_pending = 1;
            m_guess = k;
          end else begin
            m_ready = 0;
          end
        end
      end else if (synced == 4'hF) begin
        m_ready = 1;
      end
    end
    m_keys.push_back(keys);
    void'(m_keys.pop_front());
  endfunction

  // Advance the model on every active edge, or reset it with the DUT
  always @(posedge clock or negedge resetn) begin
    if (!resetn) model_reset();
    else model_step();
  end

  // Compare DUT outputs with the model just after each active edge
  always @(posedge clock) begin
    #1;
    if (player_input === 1'b1 && !pi_last) pi_rises++;
    pi_last = (player_input === 1'b1);
    if (resetn && model_on) begin
      expect_eq("cyc_player_input", player_input, m_pending);
      expect_eq("cyc_check", check, m_check());
      expect_eq("cyc_guess_tile", guess_tile, m_guess);
      expect_eq("cyc_guess_index", guess_index, m_rd);
      expect_eq("cyc_round_done", round_done, m_rdone);
      expect_eq("cyc_mismatch", mismatch, m_mis);
      expect_eq("cyc_overflow", overflow, m_ovf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic write_tile(input logic [1:0] t);
    seq_wr = 1'b1;
    seq_tile = t;
    cyc(1);
    seq_wr = 1'b0;
  endtask

  task automatic clear_seq();
    seq_clear = 1'b1;
    cyc(1);
    seq_clear = 1'b0;
  endtask

  task automatic consume();
    checkEN = 1'b1;
    cyc(1);
    checkEN = 1'b0;
  endtask

  task automatic release_keys();
    keys = 4'hF;
    cyc(3);
  endtask

  initial begin
    int rises0;
`ifdef KEY_DEBOUNCE_EN
    model_on = 1'b0;
`else
    model_on = 1'b1;
`endif
    cyc(3);
    expect_eq("reset_player_input", player_input, 0);
    expect_eq("reset_check", check, 0);
    expect_eq("reset_guess_tile", guess_tile, 0);
    expect_eq("reset_guess_index", guess_index, 0);
    expect_eq("reset_round_done", round_done, 0);
    expect_eq("reset_mismatch", mismatch, 0);
    expect_eq("reset_overflow", overflow, 0);
    resetn = 1'b1;
    playerEN = 1'b1;
    cyc(2);

`ifdef KEY_DEBOUNCE_EN
    clear_seq();
    write_tile(2'd0);
    difficulty = 5'd1;
    cyc(20);
    rises0 = pi_rises;
    keys = 4'b1110;
    cyc(5);
    keys = 4'hF;
    cyc(20);
    expect_eq("db_glitch_ignored", pi_rises - rises0, 0);
    keys = 4'b1110;
    cyc(20);
    expect_eq("db_press_pending", player_input, 1);
    expect_eq("db_press_tile", guess_tile, 0);
    expect_eq("db_press_check", check, 1);
`else
    // Sequence 2,0,3 repeated correctly
    clear_seq();
    write_tile(2'd2);
    write_tile(2'd0);
    write_tile(2'd3);
    difficulty = 5'd3;
    cyc(3);
    keys = 4'b1011;
    cyc(2);
    expect_eq("t1_latency_not_yet", player_input, 0);
    cyc(1);
    expect_eq("t1_latency_pending", player_input, 1);
    expect_eq("t1_guess_tile0", guess_tile, 2);
    expect_eq("t1_check0", check, 1);
    expect_eq("t1_index0", guess_index, 0);
    playerEN = 1'b0;
    cyc(2);
    expect_eq("t1_hold_without_playerEN", player_input, 1);
    playerEN = 1'b1;
    consume();
    expect_eq("t1_dropped", player_input, 0);
    expect_eq("t1_index1", guess_index, 1);
    release_keys();
    keys = 4'b1110;
    cyc(3);
    expect_eq("t1_guess_tile1", guess_tile, 0);
    expect_eq("t1_check1", check, 1);
    consume();
    expect_eq("t1_index2", guess_index, 2);
    release_keys();
    keys = 4'b0111;
    cyc(3);
    expect_eq("t1_guess_tile2", guess_tile, 3);
    expect_eq("t1_check2", check, 1);
    consume();
    expect_eq("t1_round_done", round_done, 1);
    expect_eq("t1_index_wrap", guess_index, 0);
    expect_eq("t1_no_mismatch", mismatch, 0);
    cyc(1);
    expect_eq("t1_round_done_pulse", round_done, 0);
    release_keys();
    consume();
    expect_eq("t1_idle_checkEN", mismatch, 0);

    // Wrong press against sequence 1,1
    clear_seq();
    write_tile(2'd1);
    write_tile(2'd1);
    difficulty = 5'd2;
    keys = 4'b1011;
    cyc(3);
    expect_eq("t2_guess_tile", guess_tile, 2);
    expect_eq("t2_check", check, 0);
    consume();
    expect_eq("t2_mismatch", mismatch, 1);
    expect_eq("t2_index", guess_index, 0);
    release_keys();

    // Two keys together, partial release, then single press
    clear_seq();
    expect_eq("t3_clear_mismatch", mismatch, 0);
    write_tile(2'd1);
    difficulty = 5'd1;
    rises0 = pi_rises;
    keys = 4'b0101;
    cyc(4);
    expect_eq("t3_multi_ignored", player_input, 0);
    keys = 4'b1101;
    cyc(4);
    expect_eq("t3_partial_release_ignored", player_input, 0);
    release_keys();
    keys = 4'b1101;
    cyc(3);
    expect_eq("t3_single_press", player_input, 1);
    expect_eq("t3_guess_tile", guess_tile, 1);
    expect_eq("t3_one_entry", pi_rises - rises0, 1);
    consume();
    expect_eq("t3_round_done", round_done, 1);
    release_keys();

    // Press with playerEN low, then playerEN raised while held
    playerEN = 1'b0;
    keys = 4'b1110;
    cyc(4);
    playerEN = 1'b1;
    cyc(4);
    expect_eq("t4_held_no_pending", player_input, 0);
    release_keys();
    keys = 4'b1110;
    cyc(3);
    expect_eq("t4_repress_pending", player_input, 1);
    consume();
    release_keys();

    // Fill past DEPTH, difficulty 0, clear overriding checkEN
    clear_seq();
    difficulty = 5'd0;
    seq_wr = 1'b1;
    seq_tile = 2'd3;
    cyc(32);
    expect_eq("t5_full_no_overflow", overflow, 0);
    cyc(1);
    seq_wr = 1'b0;
    expect_eq("t5_overflow", overflow, 1);
    keys = 4'b0111;
    cyc(3);
    expect_eq("t5_check_full", check, 1);
    consume();
    expect_eq("t5_diff0_round_done", round_done, 1);
    release_keys();
    keys = 4'b0111;
    cyc(3);
    expect_eq("t5_pending_before_clear", player_input, 1);
    seq_clear = 1'b1;
    checkEN = 1'b1;
    cyc(1);
    seq_clear = 1'b0;
    checkEN = 1'b0;
    expect_eq("t5_clear_player_input", player_input, 0);
    expect_eq("t5_clear_overflow", overflow, 0);
    expect_eq("t5_clear_round_done", round_done, 0);
    release_keys();
    keys = 4'b0111;
    cyc(3);
    expect_eq("t5_empty_check", check, 0);
    consume();
    release_keys();

    // Asynchronous reset while a press is pending
    clear_seq();
    write_tile(2'd0);
    write_tile(2'd1);
    difficulty = 5'd2;
    keys = 4'b1110;
    cyc(3);
    consume();
    expect_eq("t6_index_before_reset", guess_index, 1);
    release_keys();
    keys = 4'b1101;
    cyc(3);
    expect_eq("t6_pending_before_reset", player_input, 1);
    resetn = 1'b0;
    #2;
    expect_eq("t6_async_player_input", player_input, 0);
    expect_eq("t6_async_guess_index", guess_index, 0);
    cyc(2);
    resetn = 1'b1;
    cyc(5);
    expect_eq("t6_waits_for_release", player_input, 0);
    release_keys();
    keys = 4'b1101;
    cyc(3);
    expect_eq("t6_press_after_reset", player_input, 1);
    expect_eq("t6_check_after_reset", check, 0);
    consume();
    release_keys();
`endif

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Player-side responder to the game control FSM.
- Stores the tile sequence produced during generation and captures one-hot active-low key presses while the controller asserts playerEN.
- Answers the controller's player_input / checkEN / check handshake by comparing each captured press against the stored sequence in order.
- Sits beside the graphics datapath. Drives guess_tile so the datapath can flash the correctly pressed tile.

Parameters:
- DEPTH, 32, sequence storage entries; must be at least the maximum difficulty.
- TILE_W, 2, tile index width (4 tiles).
- DEBOUNCE_CYCLES, 500000, stable-key cycles required; used only with KEY_DEBOUNCE_EN.

Ports:
- clock  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- seq_clear  in  1  empties storage and clears all pointers/flags (new game)
- seq_wr  in  1  appends seq_tile at wr_ptr
- seq_tile  in  TILE_W  tile from random generator
- difficulty  in  5  number of tiles the player must repeat this round
- playerEN  in  1  controller is waiting for a press
- checkEN  in  1  controller is consuming the pending press
- keys  in  4  raw push-buttons, active-low, asynchronous
- player_input  out  1  a press is pending (level)
- check  out  1  pending press matches expected tile
- guess_tile  out  TILE_W  tile of the pending/last press
- guess_index  out  6  rd_ptr, number of correct presses so far this round
- round_done  out  1  one-cycle pulse after the final correct press
- mismatch  out  1  sticky wrong-press flag
- overflow  out  1  sticky; seq_wr attempted while full

Behaviour:
- Reset: all outputs 0, wr_ptr=rd_ptr=0, FSM=WAIT_RELEASE, storage contents don't-care.
- Key path:
  - 2-flop synchronizer.
  - A press is valid only when exactly one key is low after all keys were previously high.
  - Simultaneous multi-key presses are ignored until all keys are released.
- FSM states:
  - WAIT_RELEASE: waits for keys==4'b1111 (synchronized), then goes to WAIT_PRESS.
  - WAIT_PRESS:
    - If playerEN and a valid press: latch guess_tile = index of the low key (key0→0 … key3→3) and go to PENDING.
    - Presses while playerEN=0 are discarded; the FSM still requires release.
  - PENDING:
    - player_input=1.
    - check is combinational: (guess_tile == mem[rd_ptr]) && (rd_ptr < wr_ptr). It is valid in the same cycle checkEN is high, because the controller branches on check in its check state.
    - On a clock edge with checkEN=1, go to WAIT_RELEASE and drop player_input the next cycle.
    - On that edge, if check=1: rd_ptr++. If rd_ptr+1 >= difficulty, pulse round_done and reset rd_ptr to 0.
    - On that edge, if check=0: set mismatch and reset rd_ptr to 0.
- Latency: press edge at synchronizer output → player_input high 1 cycle later. Raw key to player_input is 3 cycles.
- Storage:
  - seq_wr writes mem[wr_ptr] and increments wr_ptr.
  - When wr_ptr==DEPTH the write is dropped and overflow is set.
  - Writes are accepted in any FSM state.
- seq_clear:
  - Highest synchronous priority; overrides seq_wr and checkEN in the same cycle.
  - Clears wr_ptr, rd_ptr, mismatch, overflow and player_input.
  - Sets FSM to WAIT_RELEASE.
- difficulty==0: the first correct press also pulses round_done (>= comparison). difficulty above wr_ptr makes check 0 once rd_ptr reaches wr_ptr.
- checkEN outside PENDING: ignored. playerEN dropping while PENDING: the press stays pending.
- Async reset mid-round: immediately returns all state to reset values.

Optional Feature:
- Macro: KEY_DEBOUNCE_EN.
- Defined: the synchronized key vector must be unchanged for DEBOUNCE_CYCLES consecutive cycles before the edge/release logic sees it. The counter restarts on any change. This adds DEBOUNCE_CYCLES latency.
- Undefined: the synchronized vector feeds the edge logic directly; no counter is synthesized.

Decomposition:
- Shared package:
  - tile index typedef (TILE_W bits)
  - key-to-tile constants
  - checker FSM state encoding
  - DEPTH default
- One sub-module, key_sync_edge, containing:
  - synchronizer
  - optional debounce
  - one-hot detection
  - press and all-released outputs

Test Plan:
- Write tiles 2,0,3 (difficulty=3). Press key2, checkEN; press key0, checkEN; press key3, checkEN → check=1 each time, guess_index 0→1→2→0, round_done one pulse after the third check, mismatch=0.
- Sequence 1,1 (difficulty=2). Press key2 → guess_tile=2, check=0 during checkEN, mismatch=1, rd_ptr=0.
- Press key1 and key3 together, then release, then press key1 alone with playerEN=1 → only one PENDING entry, guess_tile=1.
- Key pressed with playerEN=0, then playerEN raised while still held → no player_input until release and re-press.
- 33 seq_wr pulses with DEPTH=32 → overflow=1, wr_ptr=32. Then seq_clear → overflow=0, wr_ptr=0, player_input=0.
- Assert resetn low while PENDING, then release → player_input=0, guess_index=0, FSM waits for release. With KEY_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-cycle glitch on key0 → no press registered.
